psum_col_accum: RTL and testbench
=================================

# psum_col_accum

Column-output accumulator that sits directly below the last fixed-bit PE of each systolic-array column and consumes its `psum_fwd` chain output. It accumulates a group of partial sums, one per weight-tile pass, into a wide saturating accumulator. On the group's last beat it rounds, right-shifts, optionally applies ReLU, and saturates the result to an 8-bit activation. The result is presented on a valid/ready output towards the activation buffer.

## Interface

Parameters:
- `COL_WIDTH`, 11: half-width of the column psum; input psum is `2*COL_WIDTH` bits, signed.
- `ACC_WIDTH`, 32: accumulator width, signed; must be ≥ `2*COL_WIDTH`.
- `OUT_WIDTH`, 8: output activation width, signed.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `psum_valid`  in  1  input beat present.
- `psum_ready`  out  1  input beat may be accepted.
- `psum_in`  in  `2*COL_WIDTH`  signed column partial sum.
- `psum_last`  in  1  this beat closes the group.
- `cfg_shift`  in  5  right-shift amount, 0..`ACC_WIDTH`-1.
- `cfg_relu`  in  1  clamp negative results to 0.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  `OUT_WIDTH`  signed result.
- `out_sat`  out  1  output clipped, or accumulator saturated, in this group.
- `out_count`  out  8  beats in the group, saturating at 255.

## Operation

- Accept: a beat is accepted on an edge where `psum_valid && psum_ready`.
- Ready: `psum_ready = !out_valid || out_ready`, combinational. Input stalls only while a result is held and not being taken.
- Group state is `EMPTY` or `ACCUM`. Reset puts it in `EMPTY` with acc=0, count=0 and ovf=0.
- First beat in `EMPTY`:
  - latches `cfg_shift` and `cfg_relu` into group config registers;
  - changes to those inputs mid-group are ignored.
- Each accepted beat:
  - sign-extends `psum_in` to `ACC_WIDTH`;
  - adds it to acc, saturating to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1];
  - on saturation sets a sticky ovf;
  - increments count, saturating at 255.
- A non-last beat moves the state to `ACCUM`.
- Last beat (`psum_last=1`), with sum = saturated acc+psum computed this cycle:
  - Rounding: r = sum + (shift>0 ? 2^(shift-1) : 0), computed in `ACC_WIDTH+1` bits with no wrap.
  - Shift: q = r >>> shift (arithmetic).
  - ReLU: if relu and q<0, q=0.
  - Saturate q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; clip = 1 if clamped by this step (ReLU zeroing is not a clip).
  - Register `out_data`=q, `out_sat`=clip|ovf (including an ovf set by this beat), and `out_count`=count+1 (saturating).
  - Set `out_valid` and return to `EMPTY`, clearing acc, count and ovf.
- A group of one beat (first beat also last) is legal and uses the config presented on that beat.
- Output handshake:
  - `out_valid` falls on an edge where `out_ready=1` unless a new last beat is accepted on the same edge; in that case the new result is loaded and `out_valid` stays 1.
  - `out_data`, `out_sat` and `out_count` are stable while `out_valid && !out_ready`.
- Accumulation of the next group proceeds while a result is held, until its last beat is stalled by `psum_ready=0`.

## Timing

- Reset values: `out_valid`=0, `out_data`=0, `out_sat`=0, `out_count`=0. `psum_ready`=1 after reset.
- Latency: last beat accepted at edge N → `out_valid`=1 with the result from edge N (visible in cycle N+1).
- Throughput: one beat per cycle with `out_ready` held high, including back-to-back single-beat groups.
- `reset` asserted at any edge discards any partial group and any held result. `psum_valid` is ignored on that edge.
- `psum_ready` is the only combinational input→output path (from `out_ready`).

## Test plan

- Basic group: shift=2, relu=0, beats 100, 200, -50(last), `out_ready`=1 → one cycle after the last beat `out_data`=63, `out_count`=3, `out_sat`=0.
- Rounding and ReLU: single beat -6 with shift=2, relu=0 → `out_data`=-1. Single beat -300 with relu=1, shift=0 → `out_data`=0, `out_sat`=0. Single beat 1000 with shift=0 → `out_data`=127, `out_sat`=1.
- Config latch: shift=0 on the first beat 40, shift=4 on the last beat 40 → `out_data`=80 (shift 0 used).
- Accumulator saturation (`ACC_WIDTH`=24): five beats of 2097151, shift=16 → acc clamps at 8388607; q = 128 clips to 127; `out_sat`=1; `out_count`=5.
- Backpressure:
  - hold `out_ready`=0 after group A (result 5), then stream group B (3, 4 last);
  - → `psum_ready`=0 while B's beats wait and A stays stable;
  - raise `out_ready` for one cycle → A is taken and B is accepted;
  - B's result is 7, and its `out_valid` follows with no bubble on the same edge as the load.
- Reset mid-group: beats 10, 20, then `reset` for one cycle, then single beat 5 (last) with shift 0 → `out_data`=5, `out_count`=1.

Source files
------------

// File: rtl/psum_col_accum.sv
// Column-output accumulator: sums a group of column partial sums into a wide
// saturating accumulator, then rounds, shifts, optionally applies ReLU and
// saturates to an OUT_WIDTH activation presented on a valid/ready output.
module psum_col_accum #(
    parameter int COL_WIDTH = 11,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   psum_valid,
    output logic                   psum_ready,
    input  logic [2*COL_WIDTH-1:0] psum_in,
    input  logic                   psum_last,
    input  logic [4:0]             cfg_shift,
    input  logic                   cfg_relu,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic [7:0]             out_count
);

    localparam int PW = 2 * COL_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0]   OUT_MAX_W = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH:0]   OUT_MIN_W = -(ACC_WIDTH+1)'(2**(OUT_WIDTH-1));

    typedef enum logic {
        EMPTY,
        ACCUM
    } state_t;

    state_t state, state_next;

    logic signed [ACC_WIDTH-1:0] acc;
    logic [7:0]                  count;
    logic                        ovf;
    logic [4:0]                  shift_q;
    logic                        relu_q;

    logic                        accept;
    logic                        first;
    logic [4:0]                  shift_eff;
    logic                        relu_eff;
    logic signed [ACC_WIDTH:0]   sum_wide;
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        acc_hit;
    logic [7:0]                  count_inc;
    logic [ACC_WIDTH:0]          round_add;
    logic signed [ACC_WIDTH:0]   rounded;
    logic signed [ACC_WIDTH:0]   q;
    logic [OUT_WIDTH-1:0]        result;
    logic                        clip;

    assign psum_ready = !out_valid || out_ready;
    assign accept     = psum_valid && psum_ready;
    assign first      = (state == EMPTY);

    // Group state register.
    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    // Next group state: a last beat closes the group, any other beat opens/extends it.
    always_comb begin
        state_next = state;
        if (accept) state_next = psum_last ? EMPTY : ACCUM;
    end

    // Datapath: saturating accumulate, then round/shift/ReLU/clip of the closing sum.
    always_comb begin
        shift_eff = first ? cfg_shift : shift_q;
        relu_eff  = first ? cfg_relu  : relu_q;

        sum_wide = {acc[ACC_WIDTH-1], acc}
                 + {{(ACC_WIDTH+1-PW){psum_in[PW-1]}}, psum_in};
        acc_hit  = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
        if (acc_hit) sum = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        else         sum = sum_wide[ACC_WIDTH-1:0];

        count_inc = (count == 8'hFF) ? count : count + 8'd1;

        round_add = '0;
        if (shift_eff != 5'd0) round_add = (ACC_WIDTH+1)'(1) << (shift_eff - 5'd1);
        rounded = {sum[ACC_WIDTH-1], sum} + $signed(round_add);
        q       = rounded >>> shift_eff;
        if (relu_eff && q[ACC_WIDTH]) q = '0;

        clip = 1'b0;
        if (q > OUT_MAX_W) begin
            result = OUT_MAX_W[OUT_WIDTH-1:0];
            clip   = 1'b1;
        end else if (q < OUT_MIN_W) begin
            result = OUT_MIN_W[OUT_WIDTH-1:0];
            clip   = 1'b1;
        end else begin
            result = q[OUT_WIDTH-1:0];
        end
    end

    // Accumulator, beat counter, sticky overflow and per-group config latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else if (accept) begin
            if (first) begin
                shift_q <= cfg_shift;
                relu_q  <= cfg_relu;
            end
            if (psum_last) begin
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end else begin
                acc   <= sum;
                count <= count_inc;
                ovf   <= ovf | acc_hit;
            end
        end
    end

    // Output holding register: loads on a last beat, drains on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_count <= '0;
        end else if (accept && psum_last) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_sat   <= clip | ovf | acc_hit;
            out_count <= count_inc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psum_col_accum.sv
// Directed self-checking bench for psum_col_accum: table-driven beat stream
// plus hand-written backpressure, reset, count and accumulator-saturation cases.
module tb_psum_col_accum;

    localparam int PW = 22;

    logic            clk = 1'b0;
    logic            reset;
    logic            psum_valid, psum_ready, psum_last, cfg_relu;
    logic [PW-1:0]   psum_in;
    logic [4:0]      cfg_shift;
    logic            out_valid, out_ready, out_sat;
    logic [7:0]      out_data, out_count;

    logic            s_psum_valid, s_psum_ready, s_psum_last, s_cfg_relu;
    logic [PW-1:0]   s_psum_in;
    logic [4:0]      s_cfg_shift;
    logic            s_out_valid, s_out_ready, s_out_sat;
    logic [7:0]      s_out_data, s_out_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    psum_col_accum dut (
        .clk(clk), .reset(reset),
        .psum_valid(psum_valid), .psum_ready(psum_ready),
        .psum_in(psum_in), .psum_last(psum_last),
        .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .out_count(out_count)
    );

    psum_col_accum #(.COL_WIDTH(11), .ACC_WIDTH(24), .OUT_WIDTH(8)) dut24 (
        .clk(clk), .reset(reset),
        .psum_valid(s_psum_valid), .psum_ready(s_psum_ready),
        .psum_in(s_psum_in), .psum_last(s_psum_last),
        .cfg_shift(s_cfg_shift), .cfg_relu(s_cfg_relu),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_data(s_out_data), .out_sat(s_out_sat), .out_count(s_out_count)
    );

    typedef struct {
        int psum;
        bit last;
        int shift;
        bit relu;
        int exp_data;
        bit exp_sat;
        int exp_count;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic beat(input int v, input bit last, input int sh, input bit relu);
        int t;
        t          = v;
        psum_valid = 1'b1;
        psum_in    = t[PW-1:0];
        psum_last  = last;
        cfg_shift  = sh[4:0];
        cfg_relu   = relu;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        psum_valid = 1'b0; psum_in = '0; psum_last = 1'b0;
        cfg_shift = '0; cfg_relu = 1'b0; out_ready = 1'b1;
        s_psum_valid = 1'b0; s_psum_in = '0; s_psum_last = 1'b0;
        s_cfg_shift = '0; s_cfg_relu = 1'b0; s_out_ready = 1'b1;

        //           psum  last sh relu  data sat cnt
        vecs[0]  = '{100,   0, 2, 0,    0,  0,  0};
        vecs[1]  = '{200,   0, 2, 0,    0,  0,  0};
        vecs[2]  = '{-50,   1, 2, 0,   63,  0,  3};
        vecs[3]  = '{-6,    1, 2, 0,   -1,  0,  1};
        vecs[4]  = '{-300,  1, 0, 1,    0,  0,  1};
        vecs[5]  = '{1000,  1, 0, 0,  127,  1,  1};
        vecs[6]  = '{40,    0, 0, 0,    0,  0,  0};
        vecs[7]  = '{40,    1, 4, 0,   80,  0,  2};
        vecs[8]  = '{-1000, 1, 0, 0, -128,  1,  1};
        vecs[9]  = '{7,     1, 1, 0,    4,  0,  1};
        vecs[10] = '{-7,    1, 1, 0,   -3,  0,  1};
        vecs[11] = '{10,    0, 0, 1,    0,  0,  0};
        vecs[12] = '{-30,   1, 0, 0,    0,  0,  2};
        vecs[13] = '{127,   1, 0, 0,  127,  0,  1};

        // Reset state
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_out_sat",   out_sat, 0);
        chk("rst_out_count", out_count, 0);
        chk("rst_psum_ready", psum_ready, 1);
        reset = 1'b0;

        // Table-driven beat stream, out_ready held high
        for (int i = 0; i < 14; i++) begin
            beat(vecs[i].psum, vecs[i].last, vecs[i].shift, vecs[i].relu);
            tick();
            if (vecs[i].last) begin
                chk($sformatf("vec%0d_valid", i), out_valid, 1);
                chk($sformatf("vec%0d_data", i),  $signed(out_data), vecs[i].exp_data);
                chk($sformatf("vec%0d_sat", i),   out_sat, vecs[i].exp_sat);
                chk($sformatf("vec%0d_count", i), out_count, vecs[i].exp_count);
            end else begin
                chk($sformatf("vec%0d_valid", i), out_valid, 0);
            end
            chk($sformatf("vec%0d_ready", i), psum_ready, 1);
        end
        psum_valid = 1'b0;
        tick();
        chk("drain_valid", out_valid, 0);

        // Backpressure: A=5 held, B=3,4 waits
        out_ready = 1'b0;
        beat(5, 1, 0, 0);
        tick();
        chk("bp_a_valid", out_valid, 1);
        chk("bp_a_data",  out_data, 5);
        chk("bp_stall_ready", psum_ready, 0);
        beat(3, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("bp_hold_ready", psum_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data",  out_data, 5);
            chk("bp_hold_count", out_count, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_comb_ready", psum_ready, 1);
        tick();
        chk("bp_a_taken", out_valid, 0);
        out_ready = 1'b0;
        beat(4, 1, 0, 0);
        tick();
        chk("bp_b_valid", out_valid, 1);
        chk("bp_b_data",  out_data, 7);
        chk("bp_b_count", out_count, 2);
        psum_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_b_taken", out_valid, 0);

        // Reset mid-group discards partial sum and the beat on the reset edge
        beat(10, 0, 0, 0); tick();
        beat(20, 0, 0, 0); tick();
        beat(50, 1, 0, 0);
        reset = 1'b1;
        tick();
        chk("rmg_valid", out_valid, 0);
        reset = 1'b0;
        beat(5, 1, 0, 0);
        tick();
        chk("rmg_data",  out_data, 5);
        chk("rmg_count", out_count, 1);
        chk("rmg_sat",   out_sat, 0);

        // Beat counter saturates at 255
        for (int i = 0; i < 299; i++) begin
            beat(0, 0, 0, 0);
            tick();
        end
        beat(1, 1, 0, 0);
        tick();
        chk("cnt_sat_count", out_count, 255);
        chk("cnt_sat_data",  out_data, 1);
        psum_valid = 1'b0;

        // 24-bit accumulator saturation, then sticky ovf with in-range result
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 5; i++) begin
                s_psum_valid = 1'b1;
                s_psum_in    = 22'd2097151;
                s_psum_last  = (g == 0) && (i == 4);
                s_cfg_shift  = 5'd16;
                s_cfg_relu   = 1'b0;
                tick();
            end
            if (g == 1) begin
                s_psum_in   = 22'h200000;
                s_psum_last = 1'b1;
                tick();
            end
            s_psum_valid = 1'b0;
            chk("acc24_valid", s_out_valid, 1);
            chk("acc24_data",  $signed(s_out_data), (g == 0) ? 127 : 96);
            chk("acc24_sat",   s_out_sat, 1);
            chk("acc24_count", s_out_count, (g == 0) ? 5 : 6);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
